// File: rtl/ps2_frame_ctrl.sv
// ps2_frame_ctrl -- receive-side PS/2 keyboard frame controller.
//
// Takes the already-synchronized keyboard clock/data lines and does four jobs:
//   - detects falling edges of the keyboard clock,
//   - walks the 11-bit frame: start, 8 data bits LSB first, odd parity, stop,
//   - aborts a frame that stalls between keyboard clock edges (watchdog),
//   - hands each received byte to the consumer through a one-entry
//     valid/ready holding register.
// All outputs are registered.
//
// Build option:
//   PS2_PARITY_CHECK_EN  When defined, the odd-parity bit is checked, and a
//                        failing frame is dropped with a parity_err pulse.
//                        When undefined, the parity bit is sampled and
//                        ignored, and parity_err is tied low.

module ps2_frame_ctrl #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       kb_clk_sync,
    input  logic       kb_data_sync,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    input  logic       scan_ready,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overflow
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t            state_q,       state_d;
    logic [7:0]        shift_q,       shift_d;
    logic [2:0]        bit_cnt_q,     bit_cnt_d;
    logic [WD_W-1:0]   wdog_q,        wdog_d;
    logic              kb_clk_prev_q;
    logic [7:0]        scan_code_q,   scan_code_d;
    logic              scan_valid_q,  scan_valid_d;
    logic              parity_err_q,  parity_err_d;
    logic              frame_err_q,   frame_err_d;
    logic              overflow_q,    overflow_d;

    // ------------------------------------------------------------------
    // Derived strobes
    // ------------------------------------------------------------------
    logic            fall;
    logic            transfer;
    logic            parity_fail;
    logic [WD_W-1:0] wdog_inc;
    logic            wdog_expired;

    assign fall     = kb_clk_prev_q & ~kb_clk_sync;
    assign transfer = scan_valid_q & scan_ready;
    assign wdog_inc = wdog_q + WD_W'(1);

    // The watchdog fires when the count would reach TIMEOUT_CYCLES. A falling
    // edge in that same cycle is real progress, so it takes precedence.
    assign wdog_expired = (state_q != ST_IDLE) && !fall &&
                          (wdog_inc == WD_W'(TIMEOUT_CYCLES));

`ifdef PS2_PARITY_CHECK_EN
    logic parity_bit_q, parity_bit_d;

    // Odd parity: the data bits and the parity bit XOR to 1 on a good frame.
    assign parity_fail = ~(^{shift_q, parity_bit_q});
`else
    assign parity_fail = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state logic for the frame FSM, watchdog and output register
    // ------------------------------------------------------------------
    // Computes all next-state values; the error strobes default to 0 so
    // they are single-cycle pulses.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        scan_code_d  = scan_code_q;
        scan_valid_d = scan_valid_q & ~transfer;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;
        overflow_d   = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
        parity_bit_d = parity_bit_q;
`endif

        // The watchdog only runs inside a frame, between falling edges.
        if ((state_q == ST_IDLE) || fall) begin
            wdog_d = '0;
        end else begin
            wdog_d = wdog_inc;
        end

        if (fall) begin
            case (state_q)
                ST_IDLE: begin
                    if (!kb_data_sync) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = 3'd0;
                    end else begin
                        // A start bit must be low.
                        frame_err_d = 1'b1;
                    end
                end

                ST_DATA: begin
                    shift_d[bit_cnt_q] = kb_data_sync;
                    bit_cnt_d          = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end

                ST_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                    parity_bit_d = kb_data_sync;
`endif
                    state_d = ST_STOP;
                end

                ST_STOP: begin
                    state_d = ST_IDLE;
                    if (!kb_data_sync) begin
                        frame_err_d = 1'b1;
                    end else if (parity_fail) begin
                        parity_err_d = 1'b1;
                    end else if (!scan_valid_q || transfer) begin
                        // Free, or emptied this very cycle: the new byte goes
                        // straight in and valid stays high across the swap.
                        scan_code_d  = shift_q;
                        scan_valid_d = 1'b1;
                    end else begin
                        // Consumer is behind: keep the older byte.
                        overflow_d = 1'b1;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else if (wdog_expired) begin
            state_d     = ST_IDLE;
            frame_err_d = 1'b1;
            wdog_d      = '0;
            bit_cnt_d   = 3'd0;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // Registers every piece of state; reset may arrive mid-frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            shift_q       <= 8'h00;
            bit_cnt_q     <= 3'd0;
            wdog_q        <= '0;
            kb_clk_prev_q <= 1'b1;
            scan_code_q   <= 8'h00;
            scan_valid_q  <= 1'b0;
            parity_err_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            wdog_q        <= wdog_d;
            kb_clk_prev_q <= kb_clk_sync;
            scan_code_q   <= scan_code_d;
            scan_valid_q  <= scan_valid_d;
            parity_err_q  <= parity_err_d;
            frame_err_q   <= frame_err_d;
            overflow_q    <= overflow_d;
        end
    end

`ifdef PS2_PARITY_CHECK_EN
    // Holds the received parity bit until the stop bit is judged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_bit_q <= 1'b0;
        end else begin
            parity_bit_q <= parity_bit_d;
        end
    end
`endif

    assign scan_code  = scan_code_q;
    assign scan_valid = scan_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overflow   = overflow_q;

endmodule
